// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC/fetch stage and instruction memory.
// Word-wide read request with a single ack that returns the data.
interface pc_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches one word per request,
// hands it to decode with its sequential PC, and applies branch redirects.
module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall,
  pc_fetch_unit_if.master       imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  addr_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redir_addr;
  logic [ADDR_WIDTH-1:0] accept_target;
  logic                  redir_pend;
  logic                  redirect_hit;
  logic                  accept;
  logic                  fetch_done;

  assign pc_inc         = pc + ADDR_WIDTH'(PC_STEP);
  assign accept         = (state == VALID) && !stall;
  assign fetch_done     = (state == FETCH) && imem.imem_ack;
  assign imem.imem_addr = pc;

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) state_nxt = VALID;
      end
      VALID: if (!stall) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // A strobe on the accepting edge wins over a pending one and bypasses redir_pend.
  always_comb begin
    redirect_hit  = branch_taken || redir_pend;
    accept_target = pc_inc;
    if (branch_taken)    accept_target = branch_target;
    else if (redir_pend) accept_target = redir_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_addr     <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      redir_pend  <= 1'b0;
      redir_addr  <= '0;
      addr_err    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        redir_pend  <= 1'b0;
        pc          <= accept_target;
        instr_valid <= 1'b0;
        if (redirect_hit && (accept_target[1:0] != 2'b00)) addr_err <= 1'b1;
      end else if (branch_taken) begin
        redir_pend <= 1'b1;
        redir_addr <= branch_target;
      end

      if (fetch_done) begin
        instr       <= imem.imem_rdata;
        pc_addr     <= pc_inc;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit, plus a wrap-around sequence
// on a second instance booting from the top of the address space.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance 0: RESET_PC = 0
  logic        rst0 = 1'b1;
  logic        br0 = 1'b0;
  logic [31:0] tgt0 = '0;
  logic        stall0 = 1'b0;
  logic [31:0] instr0;
  logic        valid0;
  logic [31:0] pca0;
  logic        err0;
  pc_fetch_unit_if #(.ADDR_WIDTH(32)) bus0 ();

  pc_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut0 (
    .clk(clk), .rst(rst0), .branch_taken(br0), .branch_target(tgt0), .stall(stall0),
    .imem(bus0), .instr(instr0), .instr_valid(valid0), .pc_addr(pca0), .addr_err(err0)
  );

  // instance 1: RESET_PC at the wrap point
  logic        rst1 = 1'b1;
  logic        br1 = 1'b0;
  logic [31:0] tgt1 = '0;
  logic        stall1 = 1'b0;
  logic [31:0] instr1;
  logic        valid1;
  logic [31:0] pca1;
  logic        err1;
  pc_fetch_unit_if #(.ADDR_WIDTH(32)) bus1 ();

  pc_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
    .clk(clk), .rst(rst1), .branch_taken(br1), .branch_target(tgt1), .stall(stall1),
    .imem(bus1), .instr(instr1), .instr_valid(valid1), .pc_addr(pca1), .addr_err(err1)
  );

  typedef struct {
    logic        rst, ack, stall, br;
    logic [31:0] tgt;
    int          mode;      // 0 skip, 1 control, 2 +instr/pc_addr, 3 +reset instr/pc_addr
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pca;
    logic [31:0] fa;        // address the delivered instruction was fetched from
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h5A00_0000 + a;
  endfunction

  function automatic vec_t mk(input logic r, input logic a, input logic s, input logic b,
                              input logic [31:0] t, input int m, input logic q,
                              input logic [31:0] ad, input logic v, input logic [31:0] p,
                              input logic [31:0] f, input logic e);
    vec_t x;
    x.rst = r; x.ack = a; x.stall = s; x.br = b; x.tgt = t; x.mode = m;
    x.req = q; x.addr = ad; x.valid = v; x.pca = p; x.fa = f; x.err = e;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset, then stream with ack in every request cycle
    vecs.push_back(mk(1,0,0,0,0,      0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,      3, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      3, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h00,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h04,32'h00,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h04,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h08,32'h04,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h08,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h0C,32'h08,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h0C,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h10,32'h0C,0));
    // slow memory, then stall held in VALID
    vecs.push_back(mk(0,0,0,0,0,      1, 1,32'h10,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      1, 1,32'h10,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      1, 1,32'h10,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h10,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,1,0,0,    2, 0,0,1,32'h14,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h14,32'h10,0));
    // redirect while a fetch is outstanding: delay slot still delivered
    vecs.push_back(mk(0,0,0,1,32'h40, 1, 1,32'h14,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h14,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h18,32'h14,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h40,0,0,0,0));
    // two strobes in one VALID period: last one wins
    vecs.push_back(mk(0,0,1,1,32'h100,2, 0,0,1,32'h44,32'h40,0));
    vecs.push_back(mk(0,0,1,1,32'h80, 2, 0,0,1,32'h44,32'h40,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h44,32'h40,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h80,0,0,0,0));
    // strobe on the accepting edge overrides a pending one
    vecs.push_back(mk(0,0,1,1,32'h200,2, 0,0,1,32'h84,32'h80,0));
    vecs.push_back(mk(0,0,0,1,32'hC0, 2, 0,0,1,32'h84,32'h80,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'hC0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'hC4,32'hC0,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'hC4,0,0,0,0));
    // misaligned target: used as-is, addr_err sticky
    vecs.push_back(mk(0,0,0,1,32'h22, 2, 0,0,1,32'hC8,32'hC4,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h22,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h26,32'h22,1));
    // reset mid-fetch with ack and strobe in the reset cycle
    vecs.push_back(mk(1,1,0,1,32'h300,1, 1,32'h26,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,      3, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,      1, 1,32'h00,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,      2, 0,0,1,32'h04,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,      1, 1,32'h04,0,0,0,0));

    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
    bus1.imem_ack   = 1'b0;
    bus1.imem_rdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst0            = vecs[i].rst;
      bus0.imem_ack   = vecs[i].ack;
      bus0.imem_rdata = vecs[i].ack ? mem(vecs[i].addr) : 32'hDEAD_BEEF;
      stall0          = vecs[i].stall;
      br0             = vecs[i].br;
      tgt0            = vecs[i].tgt;
      if (vecs[i].mode != 0) begin
        chk("imem_req", i, 32'(bus0.imem_req), 32'(vecs[i].req));
        if (vecs[i].req) chk("imem_addr", i, bus0.imem_addr, vecs[i].addr);
        chk("instr_valid", i, 32'(valid0), 32'(vecs[i].valid));
        chk("addr_err", i, 32'(err0), 32'(vecs[i].err));
      end
      if (vecs[i].mode == 2) begin
        chk("instr", i, instr0, mem(vecs[i].fa));
        chk("pc_addr", i, pca0, vecs[i].pca);
      end
      if (vecs[i].mode == 3) begin
        chk("instr_rst", i, instr0, 32'h0);
        chk("pc_addr_rst", i, pca0, 32'h0);
      end
      @(posedge clk); #1;
    end
    rst0 = 1'b1;

    // wrap-around on the high RESET_PC instance
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    chk("wrap_boot_req", 100, 32'(bus1.imem_req), 32'h0);
    chk("wrap_boot_pc_addr", 100, pca1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_fetch_req", 101, 32'(bus1.imem_req), 32'h1);
    chk("wrap_fetch_addr", 101, bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_ack   = 1'b1;
    bus1.imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus1.imem_ack = 1'b0;
    chk("wrap_valid", 102, 32'(valid1), 32'h1);
    chk("wrap_instr", 102, instr1, 32'h1234_5678);
    chk("wrap_pc_addr", 102, pca1, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap_next_req", 103, 32'(bus1.imem_req), 32'h1);
    chk("wrap_next_addr", 103, bus1.imem_addr, 32'h0000_0000);
    chk("wrap_err", 103, 32'(err1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
